// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmitter and receiver: character
// codes, encoded-pattern layout, Morse timing in units, and TX FSM states.
package morse_pkg;

  // Character code space shared with morse_rx.
  localparam logic [5:0] CODE_A         = 6'd0;
  localparam logic [5:0] CODE_0         = 6'd26;
  localparam logic [5:0] CODE_SPACE     = 6'd36;
  localparam logic [5:0] CODE_MAX_VALID = 6'd36;

  // Encoded character: len symbols held right-aligned in bits, sent
  // from bits[len-1] down to bits[0]; 1 = dash, 0 = dot.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] bits;
  } morse_pattern_t;

  // Phase lengths in Morse units.
  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS  = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MARK,
    ST_SYM_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP
  } tx_state_t;

  // Symbol selected by a 1-based pointer; pointer 0 (nothing left) reads
  // as a dot so the lookup never indexes outside the pattern.
  function automatic logic sym_is_dash(input logic [4:0] bits,
                                       input logic [2:0] ptr);
    logic dash;
    dash = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ptr == 3'(i + 1)) dash = bits[i];
    end
    return dash;
  endfunction

  // Mark length for one symbol.
  function automatic logic [2:0] mark_units(input logic dash);
    return dash ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_encode_rom.sv
// Combinational character-code to Morse-pattern lookup. Codes above
// CODE_MAX_VALID report o_valid = 0; the space code is valid with len 0.
module morse_encode_rom
  import morse_pkg::*;
(
  input  logic [5:0]     i_code,
  output morse_pattern_t o_pattern,
  output logic           o_valid
);

  // Pattern table: {len, bits} with bits right-aligned, 1 = dash.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    o_pattern = '0;
    o_valid   = (i_code <= CODE_MAX_VALID);
    case (i_code)
      CODE_A:     o_pattern = {3'd2, 5'b00001}; // A .-
      6'd1:       o_pattern = {3'd4, 5'b01000}; // B -...
      6'd2:       o_pattern = {3'd4, 5'b01010}; // C -.-.
      6'd3:       o_pattern = {3'd3, 5'b00100}; // D -..
      6'd4:       o_pattern = {3'd1, 5'b00000}; // E .
      6'd5:       o_pattern = {3'd4, 5'b00010}; // F ..-.
      6'd6:       o_pattern = {3'd3, 5'b00110}; // G --.
      6'd7:       o_pattern = {3'd4, 5'b00000}; // H ....
      6'd8:       o_pattern = {3'd2, 5'b00000}; // I ..
      6'd9:       o_pattern = {3'd4, 5'b00111}; // J .---
      6'd10:      o_pattern = {3'd3, 5'b00101}; // K -.-
      6'd11:      o_pattern = {3'd4, 5'b00100}; // L .-..
      6'd12:      o_pattern = {3'd2, 5'b00011}; // M --
      6'd13:      o_pattern = {3'd2, 5'b00010}; // N -.
      6'd14:      o_pattern = {3'd3, 5'b00111}; // O ---
      6'd15:      o_pattern = {3'd4, 5'b00110}; // P .--.
      6'd16:      o_pattern = {3'd4, 5'b01101}; // Q --.-
      6'd17:      o_pattern = {3'd3, 5'b00010}; // R .-.
      6'd18:      o_pattern = {3'd3, 5'b00000}; // S ...
      6'd19:      o_pattern = {3'd1, 5'b00001}; // T -
      6'd20:      o_pattern = {3'd3, 5'b00001}; // U ..-
      6'd21:      o_pattern = {3'd4, 5'b00001}; // V ...-
      6'd22:      o_pattern = {3'd3, 5'b00011}; // W .--
      6'd23:      o_pattern = {3'd4, 5'b01001}; // X -..-
      6'd24:      o_pattern = {3'd4, 5'b01011}; // Y -.--
      6'd25:      o_pattern = {3'd4, 5'b01100}; // Z --..
      CODE_0:     o_pattern = {3'd5, 5'b11111}; // 0 -----
      6'd27:      o_pattern = {3'd5, 5'b01111}; // 1 .----
      6'd28:      o_pattern = {3'd5, 5'b00111}; // 2 ..---
      6'd29:      o_pattern = {3'd5, 5'b00011}; // 3 ...--
      6'd30:      o_pattern = {3'd5, 5'b00001}; // 4 ....-
      6'd31:      o_pattern = {3'd5, 5'b00000}; // 5 .....
      6'd32:      o_pattern = {3'd5, 5'b10000}; // 6 -....
      6'd33:      o_pattern = {3'd5, 5'b11000}; // 7 --...
      6'd34:      o_pattern = {3'd5, 5'b11100}; // 8 ---..
      6'd35:      o_pattern = {3'd5, 5'b11110}; // 9 ----.
      CODE_SPACE: o_pattern = {3'd0, 5'b00000}; // word space, no symbols
      default:    o_pattern = '0;
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: accepts one character code per valid/ready handshake
// and keys it out with standard timing (dot 1, dash 3, symbol gap 1,
// character gap 3, word gap 4 units). All outputs are registered.
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 10_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [5:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       tx_done,
  output logic       char_err
);

  localparam int               CYC_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  tx_state_t        r_state;
  tx_state_t        w_next_state;
  logic [5:0]       r_code;
  logic [4:0]       r_bits;
  logic [2:0]       r_ptr;
  logic [2:0]       w_ptr_next;
  logic [CYC_W-1:0] r_cyc;
  logic [2:0]       r_units;
  logic [2:0]       w_units_load;
  logic             w_tick;
  logic             w_phase_end;
  logic             w_accept;
  logic             w_tx_done_next;
  logic             w_err_next;
  logic             r_key;
  logic             r_busy;
  logic             r_ready;
  logic             r_tx_done;
  logic             r_err;
  morse_pattern_t   w_rom_pattern;
  logic             w_rom_valid;

  morse_encode_rom u_rom (
    .i_code    (r_code),
    .o_pattern (w_rom_pattern),
    .o_valid   (w_rom_valid)
  );

  assign w_accept    = (r_state == ST_IDLE) && char_valid && r_ready;
  assign w_tick      = (r_cyc == CYC_LAST);
  assign w_phase_end = w_tick && (r_units == 3'd1);

  // State register plus the latched code and pattern bits.
  always_ff @(posedge clk_100MHz) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (reset) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_bits  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next_state;
      r_ptr   <= w_ptr_next;
      if (w_accept) r_code <= char_data;
      if (r_state == ST_LOAD) r_bits <= w_rom_pattern.bits;
    end
  end

  // Next-state logic: phase sequencing, phase lengths and pulse requests.
  always_comb begin
    w_next_state   = r_state;
    w_units_load   = '0;
    w_ptr_next     = r_ptr;
    w_tx_done_next = 1'b0;
    w_err_next     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (!w_rom_valid) begin
          w_err_next   = 1'b1;
          w_next_state = ST_IDLE;
        end else if (r_code == CODE_SPACE) begin
          w_next_state = ST_WORD_GAP;
          w_units_load = WORD_GAP_UNITS;
        end else begin
          w_next_state = ST_MARK;
          w_ptr_next   = w_rom_pattern.len;
          w_units_load = mark_units(sym_is_dash(w_rom_pattern.bits,
                                                w_rom_pattern.len));
        end
      end
      ST_MARK: begin
        if (w_phase_end) begin
          w_ptr_next = r_ptr - 3'd1;
          if (r_ptr > 3'd1) begin
            w_next_state = ST_SYM_GAP;
            w_units_load = SYM_GAP_UNITS;
          end else begin
            w_next_state = ST_CHAR_GAP;
            w_units_load = CHAR_GAP_UNITS;
          end
        end
      end
      ST_SYM_GAP: begin
        if (w_phase_end) begin
          w_next_state = ST_MARK;
          w_units_load = mark_units(sym_is_dash(r_bits, r_ptr));
        end
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (w_phase_end) begin
          w_next_state   = ST_IDLE;
          w_tx_done_next = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Unit timing: cycle counter wraps every UNIT_CYCLES, unit counter counts
  // the remaining units of the current phase; both restart on phase entry.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_cyc   <= '0;
      r_units <= '0;
    end else if (w_next_state == ST_IDLE || w_next_state == ST_LOAD) begin
      r_cyc   <= '0;
      r_units <= '0;
    end else if (w_next_state != r_state) begin
      r_cyc   <= '0;
      r_units <= w_units_load;
    end else if (w_tick) begin
      r_cyc   <= '0;
      r_units <= r_units - 3'd1;
    end else begin
      r_cyc   <= r_cyc + 1'b1;
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_key     <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_tx_done <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_key     <= (w_next_state == ST_MARK);
      r_busy    <= (w_next_state != ST_IDLE);
      r_ready   <= (w_next_state == ST_IDLE);
      r_tx_done <= w_tx_done_next;
      r_err     <= w_err_next;
    end
  end

  assign char_ready = r_ready;
  assign key_out    = r_key;
  assign busy       = r_busy;
  assign tx_done    = r_tx_done;
  assign char_err   = r_err;

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx with UNIT_CYCLES = 4. Expected key_out runs are derived
// from a dot/dash string table, queued when a character is driven and popped
// as the observed runs complete.
module tb_morse_tx;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] char_data = '0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       key_out;
  logic       busy;
  logic       tx_done;
  logic       char_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic lvl;
    int   len;
  } seg_t;

  seg_t exp_q[$];

  string pat_tab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  morse_tx #(.UNIT_CYCLES(U)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key_out    (key_out),
    .busy       (busy),
    .tx_done    (tx_done),
    .char_err   (char_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue the expected key_out runs for one character.
  task automatic push_expected(input int code);
    seg_t  s;
    string p;
    if (code == 36) begin
      s.lvl = 1'b0; s.len = 4 * U; exp_q.push_back(s);
    end else begin
      p = pat_tab[code];
      for (int i = 0; i < p.len(); i++) begin
        s.lvl = 1'b1;
        s.len = (p.getc(i) == "-") ? 3 * U : U;
        exp_q.push_back(s);
        if (i < p.len() - 1) begin
          s.lvl = 1'b0; s.len = U; exp_q.push_back(s);
        end
      end
      s.lvl = 1'b0; s.len = 3 * U; exp_q.push_back(s);
    end
  endtask

  // Compare one completed run against the head of the scoreboard.
  task automatic close_run(input logic lvl, input int run);
    seg_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL seg_extra: got level %0b for %0d cycles, none expected", lvl, run);
    end else begin
      e = exp_q.pop_front();
      if (e.lvl !== lvl || e.len !== run) begin
        n_fail++;
        $display("FAIL seg: got level %0b for %0d cycles, expected level %0b for %0d cycles",
                 lvl, run, e.lvl, e.len);
      end
    end
  endtask

  // Wait (bounded) for ready at a falling edge, present a code, step to the
  // LOAD cycle (N+1) and check it. Leaves char_valid high if hold is set.
  task automatic send_char(input logic [5:0] code, input bit hold);
    for (int i = 0; i < 100 && char_ready !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout: char_ready=%b, expected 1", char_ready);
    end
    char_data  = code;
    char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) char_valid = 1'b0;
    n_checks++;
    if ({busy, char_ready, key_out} !== 3'b100) begin
      n_fail++;
      $display("FAIL load_cycle: busy/ready/key=%b, expected 100", {busy, char_ready, key_out});
    end
  endtask

  // Observe key_out from cycle N+2 up to the tx_done cycle, run by run.
  task automatic measure_char();
    logic lvl;
    int   run;
    bit   done;
    done = 1'b0;
    @(negedge clk);
    lvl = key_out;
    run = 1;
    for (int c = 0; c < 400 && !done; c++) begin
      n_checks++;
      if (busy !== 1'b1 || char_err !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_err: busy=%b char_err=%b, expected 1 0", busy, char_err);
      end
      @(negedge clk);
      if (tx_done === 1'b1) begin
        close_run(lvl, run);
        done = 1'b1;
        n_checks++;
        if (char_ready !== 1'b1 || key_out !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL done_cycle: ready/key/busy=%b, expected 100",
                   {char_ready, key_out, busy});
        end
      end else if (key_out === lvl) begin
        run++;
      end else begin
        close_run(lvl, run);
        lvl = key_out;
        run = 1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL tx_done_timeout: no tx_done within 400 cycles");
    end
  endtask

  task automatic check_queue_empty(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover: %0d expected runs not seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({key_out, busy, tx_done, char_err, char_ready} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_outputs: key/busy/done/err/ready=%b, expected 00000",
               {key_out, busy, tx_done, char_err, char_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (char_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b busy=%b, expected 1 0", char_ready, busy);
    end
  endtask

  task automatic test_char(input int code);
    push_expected(code);
    send_char(6'(code), 1'b0);
    measure_char();
    @(negedge clk);
    n_checks++;
    if (tx_done !== 1'b0 || char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pulse code %0d: tx_done=%b ready=%b, expected 0 1",
               code, tx_done, char_ready);
    end
    check_queue_empty("char");
  endtask

  task automatic test_invalid(input int code);
    send_char(6'(code), 1'b0);
    @(negedge clk);
    n_checks++;
    if ({char_err, char_ready, key_out, busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL invalid code %0d: err/ready/key/busy=%b, expected 1100",
               code, {char_err, char_ready, key_out, busy});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({char_err, tx_done, key_out} !== 3'b000) begin
        n_fail++;
        $display("FAIL invalid_quiet code %0d: err/done/key=%b, expected 000",
                 code, {char_err, tx_done, key_out});
      end
    end
  endtask

  task automatic test_back_to_back();
    push_expected(10);                  // K
    send_char(6'd10, 1'b1);
    char_data = 6'd2;                   // C, presented while K is sent
    push_expected(2);
    measure_char();
    @(negedge clk);                     // LOAD of C
    char_valid = 1'b0;
    n_checks++;
    if ({key_out, char_ready, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_load: key/ready/busy=%b, expected 001", {key_out, char_ready, busy});
    end
    measure_char();
    check_queue_empty("b2b");
  endtask

  task automatic test_reset_mid();
    send_char(6'd0, 1'b0);              // A
    repeat (10) @(negedge clk);         // cycle N+11, inside the second mark
    n_checks++;
    if (key_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mark: key_out=%b, expected 1", key_out);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({key_out, busy, char_ready, tx_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset: key/busy/ready/done=%b, expected 0000",
               {key_out, busy, char_ready, tx_done});
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (char_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release: ready=%b busy=%b, expected 1 0", char_ready, busy);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_done, key_out, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL mid_discard: done/key/busy=%b, expected 000", {tx_done, key_out, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_char(0);       // A
    test_char(4);       // E
    test_char(26);      // 0
    test_char(16);      // Q
    test_char(35);      // 9
    test_char(36);      // word space
    test_invalid(40);
    test_invalid(37);
    test_invalid(63);
    test_back_to_back();
    test_reset_mid();
    test_char(19);      // T, after a mid-character reset
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
# morse_tx

Morse transmitter for the decoder's character stream. Accepts one 6-bit character code per handshake, encodes it into its dot/dash pattern, and drives a single key output (LED/buzzer) with standard Morse timing. Unit timing comes from an internal counter, so no external timeout blocks are needed. Sits at the output end of the design, consuming the same character code space `morse_rx` produces, so received text can be echoed.

## Interface
- `UNIT_CYCLES`, default 10_000_000: clock cycles per Morse unit (100 ms at 100 MHz); legal range ≥ 2.

- `clk_100MHz`  in  1: single system clock.
- `reset`  in  1: synchronous, active-high.
- `char_data`  in  6: character code; 0–25 = A–Z, 26–35 = digits 0–9, 36 = word space, 37–63 invalid.
- `char_valid`  in  1: `char_data` valid.
- `char_ready`  out  1: block can accept a character.
- `key_out`  out  1: 1 = key down (mark), 0 = key up.
- `busy`  out  1: a character is in progress.
- `tx_done`  out  1: one-cycle pulse when a valid character (including space) has fully completed.
- `char_err`  out  1: one-cycle pulse when an invalid code is rejected.

## Operation
- Handshake: a character is accepted on the rising edge where `char_valid && char_ready`. `char_data` is latched on that edge and may change afterwards.
- `char_ready` is 1 only in IDLE. There is no input buffering.
- FSM states:
  - IDLE: `char_ready` = 1. On accept, go to LOAD.
  - LOAD: latched code goes through the ROM; pattern length (0–5) and bits (MSB first, 1 = dash) are registered.
    - Invalid code: pulse `char_err`, go to IDLE.
    - Code 36: go to WORD_GAP.
    - Otherwise: go to MARK.
  - MARK: `key_out` = 1 for 1 unit (dot) or 3 units (dash). Then go to SYM_GAP if symbols remain, else CHAR_GAP.
  - SYM_GAP: `key_out` = 0 for 1 unit, then MARK with the next symbol.
  - CHAR_GAP: `key_out` = 0 for 3 units, then pulse `tx_done` and go to IDLE.
  - WORD_GAP: `key_out` = 0 for 4 units, then pulse `tx_done` and go to IDLE. A space after a character therefore gives 3 + 4 = 7 units of silence.
- Counters:
  - Cycle counter: width `$clog2(UNIT_CYCLES)`, counts 0..UNIT_CYCLES-1 and wraps; the wrap marks the unit tick.
  - Unit counter: 3 bits, loaded with the phase length (1, 3 or 4) on phase entry, decremented on each tick; the phase ends on the tick where it reaches 1.
  - Both counters clear on every phase entry.
- Symbol pointer: 3 bits, counts down from the pattern length.
- `busy` = 1 in all states other than IDLE.

## Timing
- Reset values: `key_out` 0, `busy` 0, `tx_done` 0, `char_err` 0, `char_ready` 0. `char_ready` is registered and goes to 1 on the first cycle after `reset` deasserts.
- Latency: accept on edge N. LOAD is occupied during cycle N+1. `key_out` rises in cycle N+2. All outputs are registered.
- A phase of k units holds `key_out` stable for exactly k·UNIT_CYCLES cycles.
- `tx_done` is asserted in the same cycle `char_ready` returns to 1, so back-to-back characters leave no extra idle cycles beyond that one ready cycle.
- Invalid code: `char_err` is high in cycle N+2, together with `char_ready` = 1. `key_out` never rises.
- `reset` mid-character: next cycle `key_out` = 0, state is IDLE, counters are 0, and the pending character is discarded with no `tx_done`.
- `char_valid` while not ready: ignored. The source must hold the code until accepted.

## Structure
- `morse_pkg` (shared with `morse_rx`) contains:
  - character code constants: `CODE_A` = 0, `CODE_0` = 26, `CODE_SPACE` = 36, `CODE_MAX_VALID` = 36;
  - the `morse_pattern_t` struct: 3-bit len, 5-bit bits;
  - unit-length constants `DOT_UNITS` = 1, `DASH_UNITS` = 3, `SYM_GAP_UNITS` = 1, `CHAR_GAP_UNITS` = 3, `WORD_GAP_UNITS` = 4;
  - the TX state enum.
- Sub-module `morse_encode_rom`: purely combinational code → `morse_pattern_t` lookup, plus a valid flag. Its output is registered in LOAD by `morse_tx`.

## Test plan
All scenarios use UNIT_CYCLES = 4.
- Code 0 ('A', .-) → `key_out` high 4, low 4, high 12, low 12 cycles. `tx_done` pulses once; `char_ready` = 1 in the same cycle.
- Code 4 ('E', .) → high 4, low 12, then `tx_done`. Code 26 ('0', -----) → five 12-cycle marks separated by 4-cycle gaps, then a 12-cycle tail.
- Code 36 (space) → `key_out` stays 0 for 16 cycles after LOAD. `busy` = 1 throughout, then `tx_done`.
- Code 40 → `char_err` pulses in cycle N+2. `key_out` stays 0, no `tx_done`, `char_ready` = 1 in cycle N+2.
- `char_valid` held high with 'K' then 'C' → 'C' accepted on the edge after `tx_done`; `key_out` for 'C' rises 2 cycles later.
- `reset` asserted during the second mark of 'A' → `key_out` = 0 and `busy` = 0 the next cycle; `char_ready` = 1 one cycle after release; no `tx_done`.
